assoc_buffer_arbiter: RTL and testbench



---
 rtl/assoc_buffer_pkg.sv | 26 ++
 rtl/assoc_buffer_arbiter_rr_picker.sv | 34 +++
 rtl/assoc_buffer_arbiter.sv | 164 ++++++++++++++++
 tb/tb_assoc_buffer_arbiter.sv | 279 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/assoc_buffer_pkg.sv
// rtl/assoc_buffer_pkg.sv - opcodes, FSM states and accept rule shared by the arbiter
// Contents: OP_* opcode constants, state_e FSM encoding, op_accepted() helper.
package assoc_buffer_pkg;

   localparam logic [1:0] OP_READ  = 2'b00;
   localparam logic [1:0] OP_WRITE = 2'b01;
   localparam logic [1:0] OP_INC   = 2'b10;
   localparam logic [1:0] OP_CLEAR = 2'b11;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'b00,
      ST_ISSUE = 2'b01,
      ST_CHECK = 2'b10,
      ST_FLUSH = 2'b11
   } state_e;

   // Write only lands on a free entry; inc/clear only act on a valid one.
   function automatic logic op_accepted(input logic [1:0] op, input logic valid);
      case (op)
         OP_WRITE:         return !valid;
         OP_INC, OP_CLEAR: return valid;
         default:          return 1'b1;
      endcase
   endfunction

endpackage

// File: rtl/assoc_buffer_arbiter_rr_picker.sv
// rtl/assoc_buffer_arbiter_rr_picker.sv - combinational round-robin winner select
// Ports: req_i (request levels), last_i (previous winner), win_o (one-hot winner),
//        idx_o (encoded winner). win_o is all-zero when no request is pending.
module rr_picker #(
   parameter int N_REQ = 4,
   parameter int IDX_W = $clog2(N_REQ)
) (
   input  logic [N_REQ-1:0] req_i,
   input  logic [IDX_W-1:0] last_i,
   output logic [N_REQ-1:0] win_o,
   output logic [IDX_W-1:0] idx_o
);

   logic             found;
   logic [IDX_W-1:0] cand;

   // Search starts just after the previous winner and wraps, so the
   // previous winner is considered last.
   always_comb begin
      win_o = '0;
      idx_o = '0;
      found = 1'b0;
      cand  = '0;
      for (int i = 1; i <= N_REQ; i++) begin
         cand = IDX_W'((int'(last_i) + i) % N_REQ);
         if (!found && req_i[cand]) begin
            found       = 1'b1;
            win_o[cand] = 1'b1;
            idx_o       = cand;
         end
      end
   end

endmodule

// File: rtl/assoc_buffer_arbiter.sv
// rtl/assoc_buffer_arbiter.sv - round-robin command scheduler for one associative buffer
// Ports: clk_i, sync_reset_i (sync, active-high); req_i/op_i/addr_i/wdata_i packed
//        per-requester commands; gnt_o/done_o one-hot pulses; resp_data_o,
//        resp_valid_o, resp_ok_o response; flush_i sweep request; busy_o;
//        buf_* strobes/address/data to the buffer, buf_data_out_i/buf_valid_i back.
module assoc_buffer_arbiter
   import assoc_buffer_pkg::*;
#(
   parameter int N_REQ = 4,
   parameter int WIDTH = 8,
   parameter int SIZE  = 1
) (
   input  logic                   clk_i,
   input  logic                   sync_reset_i,
   input  logic [N_REQ-1:0]       req_i,
   input  logic [2*N_REQ-1:0]     op_i,
   input  logic [SIZE*N_REQ-1:0]  addr_i,
   input  logic [WIDTH*N_REQ-1:0] wdata_i,
   output logic [N_REQ-1:0]       gnt_o,
   output logic [N_REQ-1:0]       done_o,
   output logic [WIDTH-1:0]       resp_data_o,
   output logic                   resp_valid_o,
   output logic                   resp_ok_o,
   input  logic                   flush_i,
   output logic                   busy_o,
   output logic                   buf_write_o,
   output logic                   buf_inc_o,
   output logic                   buf_clear_o,
   output logic [SIZE-1:0]        buf_address_o,
   output logic [WIDTH-1:0]       buf_data_in_o,
   input  logic [WIDTH-1:0]       buf_data_out_i,
   input  logic                   buf_valid_i
);

   localparam int IDX_W = $clog2(N_REQ);

   state_e           state_q, state_d;
   logic [IDX_W-1:0] idx_q, idx_d, last_q, last_d;
   logic [1:0]       op_q, op_d;
   logic [SIZE-1:0]  addr_q, addr_d, cnt_q, cnt_d;
   logic [WIDTH-1:0] wdata_q, wdata_d;
   logic             ok_q, ok_d, flush_q, flush_d;

   logic [N_REQ-1:0] pick_win;
   logic [IDX_W-1:0] pick_idx;

   rr_picker #(.N_REQ(N_REQ), .IDX_W(IDX_W)) u_picker (
      .req_i  (req_i),
      .last_i (last_q),
      .win_o  (pick_win),
      .idx_o  (pick_idx)
   );

   always_ff @(posedge clk_i) begin
      if (sync_reset_i) begin
         state_q <= ST_IDLE;
         idx_q   <= '0;
         last_q  <= IDX_W'(N_REQ - 1);
         op_q    <= OP_READ;
         addr_q  <= '0;
         wdata_q <= '0;
         ok_q    <= 1'b0;
         flush_q <= 1'b0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         last_q  <= last_d;
         op_q    <= op_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
         ok_q    <= ok_d;
         flush_q <= flush_d;
         cnt_q   <= cnt_d;
      end
   end

   always_comb begin
      state_d       = state_q;
      idx_d         = idx_q;
      last_d        = last_q;
      op_d          = op_q;
      addr_d        = addr_q;
      wdata_d       = wdata_q;
      ok_d          = ok_q;
      cnt_d         = cnt_q;
      // Pulses arriving at any time are merged into one pending sweep.
      flush_d       = flush_q | flush_i;
      gnt_o         = '0;
      done_o        = '0;
      resp_data_o   = '0;
      resp_valid_o  = 1'b0;
      resp_ok_o     = 1'b0;
      buf_write_o   = 1'b0;
      buf_inc_o     = 1'b0;
      buf_clear_o   = 1'b0;
      buf_address_o = '0;
      buf_data_in_o = '0;
      busy_o        = (state_q != ST_IDLE);

      case (state_q)
         ST_IDLE: begin
            if (flush_q || flush_i) begin
               state_d = ST_FLUSH;
               cnt_d   = '0;
            end else if (|pick_win) begin
               // Requests only reach registers here, never the buffer pins.
               idx_d   = pick_idx;
               op_d    = op_i[int'(pick_idx)*2 +: 2];
               addr_d  = addr_i[int'(pick_idx)*SIZE +: SIZE];
               wdata_d = wdata_i[int'(pick_idx)*WIDTH +: WIDTH];
               state_d = ST_ISSUE;
            end
         end
         ST_ISSUE: begin
            gnt_o[idx_q]  = 1'b1;
            buf_address_o = addr_q;
            buf_data_in_o = wdata_q;
            buf_write_o   = (op_q == OP_WRITE);
            buf_inc_o     = (op_q == OP_INC);
            buf_clear_o   = (op_q == OP_CLEAR);
            // buf_valid_i is the pre-update state here; it decides acceptance.
            ok_d          = op_accepted(op_q, buf_valid_i);
            last_d        = idx_q;
            state_d       = ST_CHECK;
         end
         ST_CHECK: begin
            buf_address_o = addr_q;
            done_o[idx_q] = 1'b1;
            resp_data_o   = buf_data_out_i;
            resp_valid_o  = buf_valid_i;
            resp_ok_o     = ok_q;
            state_d       = ST_IDLE;
         end
         ST_FLUSH: begin
            buf_address_o = cnt_q;
            buf_clear_o   = 1'b1;
            cnt_d         = cnt_q + SIZE'(1);
            if (cnt_q == '1) begin
               flush_d = flush_i;
               state_d = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase

      // Reset silences every output in the same cycle, so an ISSUE or FLUSH
      // cut by reset drives no further strobe.
      if (sync_reset_i) begin
         gnt_o         = '0;
         done_o        = '0;
         resp_data_o   = '0;
         resp_valid_o  = 1'b0;
         resp_ok_o     = 1'b0;
         buf_write_o   = 1'b0;
         buf_inc_o     = 1'b0;
         buf_clear_o   = 1'b0;
         buf_address_o = '0;
         buf_data_in_o = '0;
         busy_o        = 1'b0;
      end
   end

endmodule

// File: tb/tb_assoc_buffer_arbiter.sv
// tb/tb_assoc_buffer_arbiter.sv - directed scoreboard bench for assoc_buffer_arbiter
module tb_assoc_buffer_arbiter;

   localparam int N = 4;
   localparam int W = 8;
   localparam int S = 1;

   logic           clk = 1'b0;
   logic           rst;
   logic [N-1:0]   req;
   logic [2*N-1:0] op;
   logic [S*N-1:0] addr;
   logic [W*N-1:0] wdata;
   logic           flush;
   logic [N-1:0]   gnt, done;
   logic [W-1:0]   resp_data, buf_data_in, buf_data_out;
   logic           resp_valid, resp_ok, busy;
   logic           buf_write, buf_inc, buf_clear, buf_valid;
   logic [S-1:0]   buf_address;

   assoc_buffer_arbiter #(.N_REQ(N), .WIDTH(W), .SIZE(S)) dut (
      .clk_i          (clk),
      .sync_reset_i   (rst),
      .req_i          (req),
      .op_i           (op),
      .addr_i         (addr),
      .wdata_i        (wdata),
      .gnt_o          (gnt),
      .done_o         (done),
      .resp_data_o    (resp_data),
      .resp_valid_o   (resp_valid),
      .resp_ok_o      (resp_ok),
      .flush_i        (flush),
      .busy_o         (busy),
      .buf_write_o    (buf_write),
      .buf_inc_o      (buf_inc),
      .buf_clear_o    (buf_clear),
      .buf_address_o  (buf_address),
      .buf_data_in_o  (buf_data_in),
      .buf_data_out_i (buf_data_out),
      .buf_valid_i    (buf_valid)
   );

   always #5 clk = ~clk;

   // Associative buffer stand-in: contents survive arbiter reset.
   logic [W-1:0] bmem_d [2**S];
   logic         bmem_v [2**S];
   initial begin
      for (int i = 0; i < 2**S; i++) begin
         bmem_d[i] = '0;
         bmem_v[i] = 1'b0;
      end
   end
   assign buf_data_out = bmem_d[buf_address];
   assign buf_valid    = bmem_v[buf_address];
   always @(posedge clk) begin
      if (buf_write && !bmem_v[buf_address]) begin
         bmem_d[buf_address] <= buf_data_in;
         bmem_v[buf_address] <= 1'b1;
      end
      if (buf_inc && bmem_v[buf_address]) bmem_d[buf_address] <= bmem_d[buf_address] + 8'd1;
      if (buf_clear && bmem_v[buf_address]) bmem_v[buf_address] <= 1'b0;
   end

   // Reference contents used to predict responses.
   logic [W-1:0] ref_d [2**S];
   logic         ref_v [2**S];

   typedef struct {
      int           r;
      logic [W-1:0] d;
      logic         v;
      logic         ok;
   } exp_t;
   exp_t exp_q[$];

   int checks = 0;
   int errors = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      checks++;
      assert (obs === expv) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
      end
   endtask

   task automatic predict(input int r, input logic [1:0] o, input int a, input logic [W-1:0] w);
      exp_t e;
      logic ok;
      ok = 1'b1;
      case (o)
         2'b01: if (!ref_v[a]) begin ref_d[a] = w; ref_v[a] = 1'b1; end else ok = 1'b0;
         2'b10: if (ref_v[a]) ref_d[a] = ref_d[a] + 8'd1; else ok = 1'b0;
         2'b11: if (ref_v[a]) ref_v[a] = 1'b0; else ok = 1'b0;
         default: ok = 1'b1;
      endcase
      e.r = r; e.d = ref_d[a]; e.v = ref_v[a]; e.ok = ok;
      exp_q.push_back(e);
   endtask

   task automatic set_cmd(input int r, input logic [1:0] o, input int a, input logic [W-1:0] w);
      op[2*r +: 2]    = o;
      addr[S*r +: S]  = S'(a);
      wdata[W*r +: W] = w;
   endtask

   task automatic wait_gnt(input int r, input string tag);
      bit seen;
      seen = 1'b0;
      for (int n = 0; n < 20 && !seen; n++) begin
         @(negedge clk);
         if (gnt[r]) seen = 1'b1;
      end
      chk(tag, 32'(seen), 32'd1);
   endtask

   task automatic drain(input string tag);
      for (int n = 0; n < 20 && exp_q.size() != 0; n++) @(negedge clk);
      chk(tag, 32'(exp_q.size()), 32'd0);
   endtask

   task automatic issue(input int r, input logic [1:0] o, input int a, input logic [W-1:0] w, input string tag);
      predict(r, o, a, w);
      set_cmd(r, o, a, w);
      req[r] = 1'b1;
      wait_gnt(r, {tag, "_gnt"});
      req[r] = 1'b0;
      drain({tag, "_done"});
   endtask

   task automatic check_quiet(input string tag);
      chk({tag, "_gnt"}, 32'(gnt), 32'd0);
      chk({tag, "_done"}, 32'(done), 32'd0);
      chk({tag, "_strobes"}, 32'({buf_write, buf_inc, buf_clear}), 32'd0);
      chk({tag, "_busy"}, 32'(busy), 32'd0);
      chk({tag, "_resp"}, 32'({resp_data, resp_valid, resp_ok}), 32'd0);
      chk({tag, "_bufad"}, 32'({buf_address, buf_data_in}), 32'd0);
   endtask

   // Response monitor: pops the scoreboard on every done pulse.
   always @(negedge clk) begin
      if (done !== '0) begin
         if (exp_q.size() == 0) begin
            chk("unexpected_done", 32'(done), 32'd0);
         end else begin
            exp_t e;
            e = exp_q.pop_front();
            chk("done_idx", 32'(done), 32'(1) << e.r);
            chk("resp_data", 32'(resp_data), 32'(e.d));
            chk("resp_valid", 32'(resp_valid), 32'(e.v));
            chk("resp_ok", 32'(resp_ok), 32'(e.ok));
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: observed timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      int gidx [5];
      int gcyc [5];
      int ng, cyc;
      int clr_addr [$];

      for (int i = 0; i < 2**S; i++) begin
         ref_d[i] = '0;
         ref_v[i] = 1'b0;
      end
      rst = 1'b1; req = '0; op = '0; addr = '0; wdata = '0; flush = 1'b0;
      repeat (2) @(negedge clk);
      check_quiet("reset_held");
      rst = 1'b0;
      @(negedge clk);
      check_quiet("reset_after");

      issue(0, 2'b01, 1, 8'h5A, "write_a1");
      issue(0, 2'b00, 1, 8'h00, "read_a1");
      issue(0, 2'b01, 1, 8'h11, "rewrite_a1");
      issue(0, 2'b10, 1, 8'h00, "inc_a1");
      issue(0, 2'b10, 0, 8'h00, "inc_a0_invalid");

      // Round robin with all requesters continuously requesting.
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      for (int r = 0; r < N; r++) set_cmd(r, 2'b00, 1, 8'h00);
      predict(0, 2'b00, 1, 8'h00);
      predict(1, 2'b00, 1, 8'h00);
      predict(2, 2'b00, 1, 8'h00);
      predict(3, 2'b00, 1, 8'h00);
      predict(0, 2'b00, 1, 8'h00);
      req = '1;
      ng = 0;
      cyc = 0;
      for (int n = 0; n < 40 && ng < 5; n++) begin
         @(negedge clk);
         cyc++;
         if (gnt != '0) begin
            chk("gnt_onehot", 32'($onehot(gnt)), 32'd1);
            for (int k = 0; k < N; k++) if (gnt[k]) gidx[ng] = k;
            gcyc[ng] = cyc;
            ng++;
            if (ng == 5) req = '0;
         end
      end
      chk("rr_count", 32'(ng), 32'd5);
      chk("rr_order0", 32'(gidx[0]), 32'd0);
      chk("rr_order1", 32'(gidx[1]), 32'd1);
      chk("rr_order2", 32'(gidx[2]), 32'd2);
      chk("rr_order3", 32'(gidx[3]), 32'd3);
      chk("rr_order4", 32'(gidx[4]), 32'd0);
      for (int k = 1; k < 5; k++) chk("rr_spacing", 32'(gcyc[k] - gcyc[k-1]), 32'd3);
      drain("rr_done");

      // Flush requested while a read is in its ISSUE cycle.
      issue(0, 2'b01, 0, 8'h33, "write_a0");
      predict(1, 2'b00, 0, 8'h00);
      set_cmd(1, 2'b00, 0, 8'h00);
      req[1] = 1'b1;
      wait_gnt(1, "flush_read_gnt");
      req[1] = 1'b0;
      flush = 1'b1;
      @(negedge clk);
      flush = 1'b0;
      for (int n = 0; n < 8; n++) begin
         @(negedge clk);
         if (buf_clear) clr_addr.push_back(int'(buf_address));
      end
      chk("flush_done", 32'(exp_q.size()), 32'd0);
      chk("flush_clears", 32'(clr_addr.size()), 32'd2);
      if (clr_addr.size() == 2) begin
         chk("flush_addr0", 32'(clr_addr[0]), 32'd0);
         chk("flush_addr1", 32'(clr_addr[1]), 32'd1);
      end
      for (int i = 0; i < 2**S; i++) ref_v[i] = 1'b0;
      issue(2, 2'b00, 0, 8'h00, "post_flush_a0");
      issue(3, 2'b00, 1, 8'h00, "post_flush_a1");

      // Reset lands in the ISSUE cycle of a write to a free entry.
      set_cmd(2, 2'b01, 0, 8'h77);
      req[2] = 1'b1;
      wait_gnt(2, "rst_issue_gnt");
      rst = 1'b1;
      #1;
      check_quiet("rst_during_issue");
      @(negedge clk);
      req[2] = 1'b0;
      check_quiet("rst_next");
      rst = 1'b0;
      @(negedge clk);
      check_quiet("rst_release");

      predict(0, 2'b00, 0, 8'h00);
      predict(2, 2'b00, 0, 8'h00);
      set_cmd(0, 2'b00, 0, 8'h00);
      set_cmd(2, 2'b00, 0, 8'h00);
      req[0] = 1'b1;
      req[2] = 1'b1;
      ng = 0;
      for (int n = 0; n < 20 && ng == 0; n++) begin
         @(negedge clk);
         if (gnt != '0) ng = 1;
      end
      chk("rst_first_winner", 32'(gnt), 32'd1);
      req[0] = 1'b0;
      wait_gnt(2, "rst_second_gnt");
      req[2] = 1'b0;
      drain("rst_done");

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
